// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: shares one memory between the CPU and the loader/debug port
// through a fixed IDLE -> ISSUE -> WAIT -> DONE sequence with a configurable read latency.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_ack,
    output logic              cpu_stall,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic              ldr_ack,
    input  logic              ldr_lock,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [1:0]        owner
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    localparam logic [1:0] OWN_NONE = 2'b00;
    localparam logic [1:0] OWN_CPU  = 2'b01;
    localparam logic [1:0] OWN_LDR  = 2'b10;

    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    logic [1:0]        state_q, state_d;
    logic [1:0]        owner_q, owner_d;
    logic              last_ldr_q, last_ldr_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] ldr_rdata_q, ldr_rdata_d;
    logic              cpu_elig;
    logic              grant_cpu;
    logic              grant_ldr;

    // The CPU is only eligible while the loader holds no lock; ties go to whoever did not own last.
    always_comb begin
        cpu_elig  = cpu_req & ~ldr_lock;
        grant_cpu = 1'b0;
        grant_ldr = 1'b0;
        if (cpu_elig && ldr_req) begin
            grant_ldr = ~last_ldr_q;
            grant_cpu = last_ldr_q;
        end else begin
            grant_cpu = cpu_elig;
            grant_ldr = ldr_req;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_ldr_d  = last_ldr_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cnt_d       = cnt_q;
        cpu_rdata_d = cpu_rdata_q;
        ldr_rdata_d = ldr_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (grant_cpu) begin
                    state_d = S_ISSUE;
                    owner_d = OWN_CPU;
                    we_d    = cpu_we;
                    addr_d  = cpu_addr;
                    wdata_d = cpu_wdata;
                end else if (grant_ldr) begin
                    state_d = S_ISSUE;
                    owner_d = OWN_LDR;
                    we_d    = ldr_we;
                    addr_d  = ldr_addr;
                    wdata_d = ldr_wdata;
                end
            end
            S_ISSUE: begin
                cnt_d   = LAT_M1;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) begin
                    if (!we_q && owner_q == OWN_CPU) cpu_rdata_d = mem_rdata;
                    if (!we_q && owner_q == OWN_LDR) ldr_rdata_d = mem_rdata;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                last_ldr_d = (owner_q == OWN_LDR);
                owner_d    = OWN_NONE;
                state_d    = S_IDLE;
            end
        endcase
    end

    // last_ldr resets to 1 so the CPU wins the first tie after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_NONE;
            last_ldr_q  <= 1'b1;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= 4'd0;
            cpu_rdata_q <= '0;
            ldr_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_ldr_q  <= last_ldr_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            cpu_rdata_q <= cpu_rdata_d;
            ldr_rdata_q <= ldr_rdata_d;
        end
    end

    assign mem_en    = (state_q == S_ISSUE);
    assign mem_we    = mem_en & we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign owner     = owner_q;
    assign cpu_ack   = (state_q == S_DONE) && (owner_q == OWN_CPU);
    assign ldr_ack   = (state_q == S_DONE) && (owner_q == OWN_LDR);
    assign cpu_stall = cpu_req & ~cpu_ack;
    assign cpu_rdata = cpu_rdata_q;
    assign ldr_rdata = ldr_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a MEM_LAT=2 instance driven by a vector table and corner-case
// sequences, plus a MEM_LAT=1 instance for the minimum-latency path.
module tb_mem_port_arbiter;

    localparam int LAT = 2;
    localparam logic [31:0] JUNK = 32'hBAD0_BAD0;

    logic        clk;
    logic        rst_n;
    logic        cpu_req, cpu_we, ldr_req, ldr_we, ldr_lock;
    logic [31:0] cpu_addr, cpu_wdata, ldr_addr, ldr_wdata;
    logic [31:0] cpu_rdata, ldr_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        cpu_ack, cpu_stall, ldr_ack, mem_en, mem_we;
    logic [1:0]  owner;

    logic        cpu_req_b, cpu_we_b, ldr_req_b, ldr_we_b, ldr_lock_b;
    logic [31:0] cpu_addr_b, cpu_wdata_b, ldr_addr_b, ldr_wdata_b;
    logic [31:0] cpu_rdata_b, ldr_rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b;
    logic        cpu_ack_b, cpu_stall_b, ldr_ack_b, mem_en_b, mem_we_b;
    logic [1:0]  owner_b;

    int checks = 0;
    int errors = 0;

    logic [31:0] exp_cpu_q[$];
    logic [31:0] exp_ldr_q[$];
    logic [31:0] exp_cpu_last, exp_ldr_last;

    logic [31:0] mem   [logic [31:0]];
    logic [31:0] mem_b [logic [31:0]];
    logic [31:0] rd_addr_a, rd_addr_b;
    int          lat_a, lat_b;

    typedef struct {
        logic        is_ldr;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
    } vec_t;
    vec_t vecs[8];

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_addr(ldr_addr), .ldr_wdata(ldr_wdata),
        .ldr_rdata(ldr_rdata), .ldr_ack(ldr_ack), .ldr_lock(ldr_lock),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .owner(owner)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req_b), .cpu_we(cpu_we_b), .cpu_addr(cpu_addr_b), .cpu_wdata(cpu_wdata_b),
        .cpu_rdata(cpu_rdata_b), .cpu_ack(cpu_ack_b), .cpu_stall(cpu_stall_b),
        .ldr_req(ldr_req_b), .ldr_we(ldr_we_b), .ldr_addr(ldr_addr_b), .ldr_wdata(ldr_wdata_b),
        .ldr_rdata(ldr_rdata_b), .ldr_ack(ldr_ack_b), .ldr_lock(ldr_lock_b),
        .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
        .mem_rdata(mem_rdata_b), .owner(owner_b)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rd_a(input logic [31:0] a);
        return mem.exists(a) ? mem[a] : 32'h0;
    endfunction

    function automatic logic [31:0] rd_b(input logic [31:0] a);
        return mem_b.exists(a) ? mem_b[a] : 32'h0;
    endfunction

    // Memory responders: read data is valid only in cycle issue+MEM_LAT, junk otherwise.
    always @(negedge clk) begin
        if (!rst_n) begin
            lat_a = 0;
            mem_rdata = JUNK;
        end else if (mem_en) begin
            if (mem_we) mem[mem_addr] = mem_wdata;
            rd_addr_a = mem_addr;
            lat_a = LAT;
            mem_rdata = JUNK;
        end else if (lat_a > 0) begin
            lat_a--;
            mem_rdata = (lat_a == 0) ? rd_a(rd_addr_a) : JUNK;
        end else begin
            mem_rdata = JUNK;
        end
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            lat_b = 0;
            mem_rdata_b = JUNK;
        end else if (mem_en_b) begin
            if (mem_we_b) mem_b[mem_addr_b] = mem_wdata_b;
            rd_addr_b = mem_addr_b;
            lat_b = 1;
            mem_rdata_b = JUNK;
        end else if (lat_b > 0) begin
            lat_b--;
            mem_rdata_b = (lat_b == 0) ? rd_b(rd_addr_b) : JUNK;
        end else begin
            mem_rdata_b = JUNK;
        end
    end

    // Scoreboard: each ack pops the requester's expected rdata.
    always @(negedge clk) begin
        if (rst_n) begin
            if (cpu_ack || ldr_ack) chk("single_ack", cpu_ack & ldr_ack, 0);
            if (cpu_ack) begin
                chk("cpu_ack_expected", exp_cpu_q.size() != 0, 1);
                if (exp_cpu_q.size() != 0) chk("cpu_rdata", cpu_rdata, exp_cpu_q.pop_front());
            end
            if (ldr_ack) begin
                chk("ldr_ack_expected", exp_ldr_q.size() != 0, 1);
                if (exp_ldr_q.size() != 0) chk("ldr_rdata", ldr_rdata, exp_ldr_q.pop_front());
            end
        end
    end

    task automatic apply_reset();
        rst_n = 1'b0;
        cpu_req = 1'b0;
        ldr_req = 1'b0;
        ldr_lock = 1'b0;
        repeat (2) @(posedge clk);
        exp_cpu_q.delete();
        exp_ldr_q.delete();
        exp_cpu_last = '0;
        exp_ldr_last = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Driver: called in an IDLE cycle (cycle 0); returns in the next IDLE cycle.
    task automatic run_txn(input logic is_ldr, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [31:0] exp_rdata);
        if (is_ldr) begin
            ldr_we = we; ldr_addr = addr; ldr_wdata = wdata; ldr_req = 1'b1;
            if (!we) exp_ldr_last = exp_rdata;
            exp_ldr_q.push_back(exp_ldr_last);
        end else begin
            cpu_we = we; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
            if (!we) exp_cpu_last = exp_rdata;
            exp_cpu_q.push_back(exp_cpu_last);
        end
        for (int n = 0; n <= LAT + 2; n++) begin
            @(negedge clk);
            chk("owner", owner, (n == 0) ? 2'b00 : (is_ldr ? 2'b10 : 2'b01));
            chk("mem_en", mem_en, n == 1);
            chk("mem_we", mem_we, (n == 1) && we);
            if (is_ldr) chk("ldr_ack_cycle", ldr_ack, n == LAT + 2);
            else begin
                chk("cpu_ack_cycle", cpu_ack, n == LAT + 2);
                chk("cpu_stall", cpu_stall, n != LAT + 2);
            end
            if (n == 1) begin
                chk("mem_addr", mem_addr, addr);
                if (we) chk("mem_wdata", mem_wdata, wdata);
            end
            if (n == 0) begin
                @(posedge clk);
                #1;
                if (is_ldr) begin ldr_addr = addr ^ 32'hFFF0; ldr_wdata = 32'h0; end
                else begin cpu_addr = addr ^ 32'hFFF0; cpu_wdata = 32'h0; end
            end
        end
        @(posedge clk);
        #1;
        if (is_ldr) ldr_req = 1'b0;
        else cpu_req = 1'b0;
    endtask

    initial begin
        logic [31:0] r_addr, r_data;
        rst_n = 1'b0;
        cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
        ldr_req = 0; ldr_we = 0; ldr_addr = 0; ldr_wdata = 0; ldr_lock = 0;
        cpu_req_b = 0; cpu_we_b = 0; cpu_addr_b = 0; cpu_wdata_b = 0;
        ldr_req_b = 0; ldr_we_b = 0; ldr_addr_b = 0; ldr_wdata_b = 0; ldr_lock_b = 0;
        mem[32'h10] = 32'hDEADBEEF;
        mem[32'h30] = 32'hC0FFEE00;
        mem_b[32'h40] = 32'h12345678;

        r_addr = 32'h400 + {22'h0, 8'($urandom_range(0, 63)), 2'b00};
        r_data = $urandom;
        vecs[0] = '{1'b0, 1'b1, 32'h100, 32'h11112222, 32'h0};
        vecs[1] = '{1'b1, 1'b1, 32'h104, 32'h33334444, 32'h0};
        vecs[2] = '{1'b0, 1'b0, 32'h104, 32'h0, 32'h33334444};
        vecs[3] = '{1'b1, 1'b0, 32'h100, 32'h0, 32'h11112222};
        vecs[4] = '{1'b0, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF};
        vecs[5] = '{1'b0, 1'b1, 32'h20, 32'hA5A5A5A5, 32'h0};
        vecs[6] = '{1'b1, 1'b1, r_addr, r_data, 32'h0};
        vecs[7] = '{1'b0, 1'b0, r_addr, 32'h0, r_data};

        apply_reset();
        chk("rst_owner", owner, 2'b00);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_cpu_rdata", cpu_rdata, 32'h0);
        chk("rst_ldr_ack", ldr_ack, 0);

        // MEM_LAT=1: loader read, issue at 1, capture at 2, ack at 3.
        ldr_we_b = 1'b0; ldr_addr_b = 32'h40; ldr_req_b = 1'b1;
        for (int n = 0; n <= 3; n++) begin
            @(negedge clk);
            chk("lat1_mem_en", mem_en_b, n == 1);
            chk("lat1_ldr_ack", ldr_ack_b, n == 3);
            chk("lat1_owner", owner_b, (n == 0) ? 2'b00 : 2'b10);
            if (n == 3) chk("lat1_ldr_rdata", ldr_rdata_b, 32'h12345678);
        end
        @(posedge clk);
        #1;
        ldr_req_b = 1'b0;

        for (int i = 0; i < 8; i++)
            run_txn(vecs[i].is_ldr, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata);

        // Lock: loader writes go through while a CPU read is held off.
        cpu_we = 1'b0; cpu_addr = 32'h30; cpu_req = 1'b1; ldr_lock = 1'b1;
        for (int i = 0; i < 4; i++)
            run_txn(1'b1, 1'b1, 32'(i * 4), 32'(i + 1), 32'h0);
        chk("lock_mem0", rd_a(32'h0), 32'h1);
        chk("lock_memc", rd_a(32'hC), 32'h4);
        ldr_lock = 1'b0;
        run_txn(1'b0, 1'b0, 32'h30, 32'h0, 32'hC0FFEE00);

        // Reset during WAIT drops the transaction and restores the CPU tie priority.
        cpu_we = 1'b0; cpu_addr = 32'h10; cpu_req = 1'b1;
        repeat (3) @(negedge clk);
        chk("pre_rst_owner", owner, 2'b01);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_owner", owner, 2'b00);
        chk("mid_rst_mem_en", mem_en, 0);
        chk("mid_rst_mem_we", mem_we, 0);
        chk("mid_rst_mem_addr", mem_addr, 32'h0);
        chk("mid_rst_mem_wdata", mem_wdata, 32'h0);
        chk("mid_rst_cpu_rdata", cpu_rdata, 32'h0);
        chk("mid_rst_ldr_rdata", ldr_rdata, 32'h0);
        chk("mid_rst_acks", {cpu_ack, ldr_ack}, 2'b00);
        apply_reset();

        // Tie from reset release: CPU, loader, CPU, loader, 5 cycles apart.
        cpu_we = 1'b0; cpu_addr = 32'h10; cpu_req = 1'b1;
        ldr_we = 1'b0; ldr_addr = 32'h100; ldr_req = 1'b1;
        repeat (2) exp_cpu_q.push_back(32'hDEADBEEF);
        repeat (2) exp_ldr_q.push_back(32'h11112222);
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            chk("rr_cpu_ack", cpu_ack, (n == 4) || (n == 14));
            chk("rr_ldr_ack", ldr_ack, (n == 9) || (n == 19));
            chk("rr_owner", owner, ((n % 5) == 0) ? 2'b00 : (((n / 5) % 2 == 0) ? 2'b01 : 2'b10));
        end
        @(posedge clk);
        #1;
        cpu_req = 1'b0;
        ldr_req = 1'b0;
        repeat (4) @(posedge clk);

        chk("cpu_q_drained", 64'(exp_cpu_q.size()), 0);
        chk("ldr_q_drained", 64'(exp_ldr_q.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
